// File: rtl/vga_window_scan.sv
// VGA raster generator that scans a SCALE-replicated source window out of a
// double-buffered frame store, with repeat counting and frame-boundary buffer swaps.
module vga_window_scan #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int PIX_DIV   = 2,
  parameter int WIN_X0    = 0,
  parameter int WIN_Y0    = 0,
  parameter int WIN_W     = 64,
  parameter int WIN_H     = 56,
  parameter int SCALE     = 8,
  parameter int REPEAT    = 64,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              frame_valid,
  output logic [ADDR_W-1:0] addr,
  output logic [23:0]       rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic              pix_tick,
  output logic              rep_frame,
  output logic              end_frame,
  output logic              frame_pending,
  output logic              buf_sel
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = $clog2(PIX_DIV);
  localparam int IW = ADDR_W - 1;
  localparam int CW = $clog2(REPEAT + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DISP   = HW'(H_DISPLAY);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] X_BEG    = HW'(WIN_X0);
  localparam logic [HW-1:0] X_END    = HW'(WIN_X0 + WIN_W * SCALE);
  localparam logic [HW-1:0] X_LAST   = HW'(WIN_X0 + WIN_W * SCALE - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DISP   = VW'(V_DISPLAY);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_DISPLAY + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] Y_BEG    = VW'(WIN_Y0);
  localparam logic [VW-1:0] Y_END    = VW'(WIN_Y0 + WIN_H * SCALE);
  localparam logic [VW-1:0] Y_LAST   = VW'(WIN_Y0 + WIN_H * SCALE - 1);
  localparam logic [3:0]    SC_LAST  = 4'(SCALE - 1);
  localparam logic [IW-1:0] ROW_STEP = IW'(WIN_W);
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT - 1);

  typedef struct packed {
    logic win;
    logic blank;
    logic hs;
    logic vs;
  } ctrl_t;
  localparam ctrl_t CTRL_RST = '{win: 1'b0, blank: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL};

  logic [DW-1:0] div_cnt;
  logic [HW-1:0] h_cnt, h_next;
  logic [VW-1:0] v_cnt, v_next;
  logic          h_wrap, in_x, in_y;
  logic [3:0]    x_sub, y_sub;
  logic [IW-1:0] sx, row_base;
  logic [CW-1:0] disp_cnt;
  logic          swap_req, win_end, frame_tick;
  ctrl_t         ctrl_c;
  ctrl_t [1:0]   ctrl_pipe;

  always_comb begin
    h_wrap       = (h_cnt == H_LAST);
    h_next       = h_wrap ? '0 : h_cnt + HW'(1);
    v_next       = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    ctrl_c.win   = in_x && in_y;
    ctrl_c.blank = (h_cnt < H_DISP) && (v_cnt < V_DISP);
    ctrl_c.hs    = (h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
    ctrl_c.vs    = (v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
    win_end      = pix_tick && ctrl_c.win && (h_cnt == X_LAST) && (v_cnt == Y_LAST);
    frame_tick   = pix_tick && h_wrap && (v_cnt == V_LAST);
  end

  // Raster counters plus incremental window sub-counters: sx counts source
  // columns, row_base accumulates sy*WIN_W one source row at a time.
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_cnt  <= '0;
      pix_tick <= 1'b0;
      h_cnt    <= '0;
      v_cnt    <= '0;
      in_x     <= (WIN_X0 == 0);
      in_y     <= (WIN_Y0 == 0);
      x_sub    <= '0;
      y_sub    <= '0;
      sx       <= '0;
      row_base <= '0;
    end else begin
      pix_tick <= (div_cnt == DIV_LAST);
      div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
      if (pix_tick) begin
        h_cnt <= h_next;
        if (h_next == X_BEG) begin
          in_x  <= 1'b1;
          x_sub <= '0;
          sx    <= '0;
        end else if (h_next == X_END) begin
          in_x <= 1'b0;
        end else if (in_x) begin
          if (x_sub == SC_LAST) begin
            x_sub <= '0;
            sx    <= sx + IW'(1);
          end else begin
            x_sub <= x_sub + 4'd1;
          end
        end
        if (h_wrap) begin
          v_cnt <= v_next;
          if (v_next == Y_BEG) begin
            in_y     <= 1'b1;
            y_sub    <= '0;
            row_base <= '0;
          end else if (v_next == Y_END) begin
            in_y <= 1'b0;
          end else if (in_y) begin
            if (y_sub == SC_LAST) begin
              y_sub    <= '0;
              row_base <= row_base + ROW_STEP;
            end else begin
              y_sub <= y_sub + 4'd1;
            end
          end
        end
      end
    end
  end

  // addr -> RAM (1 clock) -> rgb register; control rides two stages to stay aligned.
  always_ff @(posedge clock) begin
    if (!reset) begin
      addr      <= '0;
      ctrl_pipe <= {CTRL_RST, CTRL_RST};
      rgb       <= '0;
      blank     <= 1'b0;
      hsync     <= ~SYNC_POL;
      vsync     <= ~SYNC_POL;
    end else begin
      if (ctrl_c.win) addr <= {buf_sel, row_base + sx};
      ctrl_pipe[0] <= ctrl_c;
      ctrl_pipe[1] <= ctrl_pipe[0];
      rgb   <= (ctrl_pipe[1].win && ctrl_pipe[1].blank) ? {3{data[DATA_W-1 -: 8]}} : 24'd0;
      blank <= ctrl_pipe[1].blank;
      hsync <= ctrl_pipe[1].hs;
      vsync <= ctrl_pipe[1].vs;
    end
  end

  // Repeat counting and buffer swap; the swap is only taken on the frame wrap.
  always_ff @(posedge clock) begin
    if (!reset) begin
      disp_cnt      <= '0;
      swap_req      <= 1'b0;
      buf_sel       <= 1'b0;
      frame_pending <= 1'b0;
      rep_frame     <= 1'b0;
      end_frame     <= 1'b0;
    end else begin
      rep_frame <= 1'b0;
      end_frame <= 1'b0;
      if (frame_valid && !swap_req) swap_req <= 1'b1;
      if (frame_tick && swap_req) begin
        buf_sel       <= ~buf_sel;
        disp_cnt      <= '0;
        swap_req      <= 1'b0;
        frame_pending <= 1'b0;
      end else if (win_end) begin
        if (frame_pending) begin
          rep_frame <= 1'b1;
        end else if (disp_cnt == REP_LAST) begin
          end_frame     <= 1'b1;
          frame_pending <= 1'b1;
          disp_cnt      <= disp_cnt + CW'(1);
        end else begin
          rep_frame <= 1'b1;
          disp_cnt  <= disp_cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_window_scan.sv
// Directed bench for vga_window_scan on a shrunken 24x16 raster with a 4x3
// source window at (2,1), SCALE 2, PIX_DIV 2, REPEAT 4.
module tb_vga_window_scan;
  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  data = '0;
  logic        frame_valid;
  logic [12:0] addr;
  logic [23:0] rgb;
  logic        hsync, vsync, blank, pix_tick, rep_frame, end_frame, frame_pending, buf_sel;

  int cyc = 0;
  int n_vec = 0;
  int n_fail = 0;

  vga_window_scan #(
    .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(1'b0), .PIX_DIV(2),
    .WIN_X0(2), .WIN_Y0(1), .WIN_W(4), .WIN_H(3), .SCALE(2),
    .REPEAT(4), .DATA_W(8), .ADDR_W(13)
  ) dut (
    .clock(clock), .reset(reset), .data(data), .frame_valid(frame_valid),
    .addr(addr), .rgb(rgb), .hsync(hsync), .vsync(vsync), .blank(blank),
    .pix_tick(pix_tick), .rep_frame(rep_frame), .end_frame(end_frame),
    .frame_pending(frame_pending), .buf_sel(buf_sel)
  );

  always #5 clock = ~clock;

  // Frame store with 1-clock read latency; content is the low address byte.
  always_ff @(posedge clock) data <= addr[7:0];

  // Screen pixel (h,v) = p = v*24+h; its outputs show at cycle 2p+4, its addr at 2p+2.
  typedef struct {
    int          cyc;
    logic        blank;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    logic [12:0] addr;
  } vec_t;
  vec_t vt[17];

  task automatic tick();
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic run_vectors(input int n);
    for (int i = 0; i < n; i++) begin
      wait_until(vt[i].cyc - 2);
      chk($sformatf("v%0d.addr", i), 32'(addr), 32'(vt[i].addr));
      wait_until(vt[i].cyc);
      chk($sformatf("v%0d.blank", i), 32'(blank), 32'(vt[i].blank));
      chk($sformatf("v%0d.hsync", i), 32'(hsync), 32'(vt[i].hs));
      chk($sformatf("v%0d.vsync", i), 32'(vsync), 32'(vt[i].vs));
      chk($sformatf("v%0d.rgb", i), 32'(rgb), 32'(vt[i].rgb));
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".addr"}, 32'(addr), 32'h0);
    chk({nm, ".rgb"}, 32'(rgb), 32'h0);
    chk({nm, ".blank"}, 32'(blank), 32'h0);
    chk({nm, ".pix_tick"}, 32'(pix_tick), 32'h0);
    chk({nm, ".rep"}, 32'(rep_frame), 32'h0);
    chk({nm, ".end"}, 32'(end_frame), 32'h0);
    chk({nm, ".pend"}, 32'(frame_pending), 32'h0);
    chk({nm, ".buf_sel"}, 32'(buf_sel), 32'h0);
    chk({nm, ".hsync"}, 32'(hsync), 32'h1);
    chk({nm, ".vsync"}, 32'(vsync), 32'h1);
  endtask

  // Window-end pulse of frame f lands at cycle 309 + 768*(f-1).
  task automatic chk_frame(input int c, input logic rep, input logic ef, input logic pend);
    wait_until(c);
    chk($sformatf("rep@%0d", c), 32'(rep_frame), 32'(rep));
    chk($sformatf("end@%0d", c), 32'(end_frame), 32'(ef));
    chk($sformatf("pend@%0d", c), 32'(frame_pending), 32'(pend));
    tick();
    chk($sformatf("rep_width@%0d", c), 32'(rep_frame | end_frame), 32'h0);
  endtask

  initial begin
    //          cyc  blank hs    vs    rgb        addr       (h,v)
    vt[0]  = '{4,   1'b1, 1'b1, 1'b1, 24'h0,     13'h000};  // (0,0)
    vt[1]  = '{60,  1'b1, 1'b1, 1'b1, 24'h010101, 13'h001}; // (4,1)
    vt[2]  = '{116, 1'b1, 1'b1, 1'b1, 24'h030303, 13'h003}; // (8,2)
    vt[3]  = '{150, 1'b1, 1'b1, 1'b1, 24'h0,     13'h003};  // (1,3)
    vt[4]  = '{152, 1'b1, 1'b1, 1'b1, 24'h040404, 13'h004}; // (2,3)
    vt[5]  = '{158, 1'b1, 1'b1, 1'b1, 24'h050505, 13'h005}; // (5,3)
    vt[6]  = '{180, 1'b0, 1'b1, 1'b1, 24'h0,     13'h007};  // (16,3)
    vt[7]  = '{182, 1'b0, 1'b1, 1'b1, 24'h0,     13'h007};  // (17,3)
    vt[8]  = '{184, 1'b0, 1'b0, 1'b1, 24'h0,     13'h007};  // (18,3)
    vt[9]  = '{188, 1'b0, 1'b0, 1'b1, 24'h0,     13'h007};  // (20,3)
    vt[10] = '{190, 1'b0, 1'b1, 1'b1, 24'h0,     13'h007};  // (21,3)
    vt[11] = '{310, 1'b1, 1'b1, 1'b1, 24'h0b0b0b, 13'h00b}; // (9,6)
    vt[12] = '{312, 1'b1, 1'b1, 1'b1, 24'h0,     13'h00b};  // (10,6)
    vt[13] = '{580, 1'b0, 1'b1, 1'b1, 24'h0,     13'h00b};  // (0,12)
    vt[14] = '{628, 1'b0, 1'b1, 1'b0, 24'h0,     13'h00b};  // (0,13)
    vt[15] = '{686, 1'b0, 1'b1, 1'b0, 24'h0,     13'h00b};  // (5,14)
    vt[16] = '{724, 1'b0, 1'b1, 1'b1, 24'h0,     13'h00b};  // (0,15)

    reset = 1'b0;
    frame_valid = 1'b0;
    repeat (3) tick();
    chk_reset("rst0");
    reset = 1'b1;
    cyc = 0;
    tick();
    chk("tick@1", 32'(pix_tick), 32'h0);
    tick();
    chk("tick@2", 32'(pix_tick), 32'h1);
    chk("blank@2", 32'(blank), 32'h0);
    tick();
    chk("tick@3", 32'(pix_tick), 32'h0);
    run_vectors(17);

    chk_frame(1077, 1'b1, 1'b0, 1'b0);
    chk_frame(1845, 1'b1, 1'b0, 1'b0);
    chk_frame(2613, 1'b0, 1'b1, 1'b1);
    chk_frame(3381, 1'b1, 1'b0, 1'b1);

    // Swap request mid frame 5, plus a second request that must be ignored.
    wait_until(3499);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    wait_until(3599);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    wait_until(3840);
    chk("buf_sel@3840", 32'(buf_sel), 32'h0);
    chk("pend@3840", 32'(frame_pending), 32'h1);
    tick();
    chk("buf_sel@3841", 32'(buf_sel), 32'h1);
    chk("pend@3841", 32'(frame_pending), 32'h0);
    wait_until(3893);
    chk("addr@3893", 32'(addr), 32'h00b);
    tick();
    chk("addr@3894", 32'(addr), 32'h1000);
    chk_frame(4149, 1'b1, 1'b0, 1'b0);
    wait_until(4609);
    chk("buf_sel@4609", 32'(buf_sel), 32'h1);
    chk_frame(4917, 1'b1, 1'b0, 1'b0);
    chk_frame(5685, 1'b1, 1'b0, 1'b0);

    // frame_valid coincident with the window end that raises end_frame.
    wait_until(6452);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    chk("end@6453", 32'(end_frame), 32'h1);
    chk("pend@6453", 32'(frame_pending), 32'h1);
    chk("rep@6453", 32'(rep_frame), 32'h0);
    wait_until(6912);
    chk("buf_sel@6912", 32'(buf_sel), 32'h1);
    chk("pend@6912", 32'(frame_pending), 32'h1);
    tick();
    chk("buf_sel@6913", 32'(buf_sel), 32'h0);
    chk("pend@6913", 32'(frame_pending), 32'h0);

    // Mid-line reset for 3 clocks, then the raster must restart from (0,0).
    wait_until(7010);
    reset = 1'b0;
    tick();
    chk_reset("rst1");
    tick();
    tick();
    chk_reset("rst3");
    reset = 1'b1;
    cyc = 0;
    tick();
    chk("re_tick@1", 32'(pix_tick), 32'h0);
    tick();
    chk("re_tick@2", 32'(pix_tick), 32'h1);
    run_vectors(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
